// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit.
//   - funct3 encodings for the supported load/store widths
//   - control state enumeration
//   - byte/halfword lane masks and a lane-mask helper used by the RMW merge
package lsu_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [0:0] {
        ST_IDLE      = 1'b0,
        ST_RMW_WRITE = 1'b1
    } lsu_state_e;

    localparam logic [31:0] LANE_MASK_B0 = 32'h0000_00FF;
    localparam logic [31:0] LANE_MASK_B1 = 32'h0000_FF00;
    localparam logic [31:0] LANE_MASK_B2 = 32'h00FF_0000;
    localparam logic [31:0] LANE_MASK_B3 = 32'hFF00_0000;
    localparam logic [31:0] LANE_MASK_H0 = 32'h0000_FFFF;
    localparam logic [31:0] LANE_MASK_H1 = 32'hFFFF_0000;
    localparam logic [31:0] LANE_MASK_W  = 32'hFFFF_FFFF;
    localparam logic [31:0] LANE_MASK_NONE = 32'h0000_0000;

    // Bytes of the memory word that a store of width f3 at byte offset off replaces.
    // Unknown widths replace nothing, so a merge with them returns the old word.
    function automatic logic [31:0] lane_mask(input logic [2:0] f3, input logic [1:0] off);
        logic [31:0] m;
        m = LANE_MASK_NONE;
        case (f3)
            F3_B: begin
                case (off)
                    2'b00:   m = LANE_MASK_B0;
                    2'b01:   m = LANE_MASK_B1;
                    2'b10:   m = LANE_MASK_B2;
                    2'b11:   m = LANE_MASK_B3;
                    default: m = LANE_MASK_NONE;
                endcase
            end
            F3_H:    m = off[1] ? LANE_MASK_H1 : LANE_MASK_H0;
            F3_W:    m = LANE_MASK_W;
            default: m = LANE_MASK_NONE;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/lsu_extract_merge.sv
// Combinational lane logic shared by the load path and the store RMW path.
//   mem_word    in  32  word currently read from memory
//   byte_off    in  2   byte offset within the word (address[1:0])
//   funct3      in  3   access width / signedness
//   store_data  in  32  right-aligned store data
//   load_data   out 32  selected lane(s), sign/zero extended; 0 for unknown funct3
//   merged_word out 32  mem_word with the store lane(s) replaced
module lsu_extract_merge
    import lsu_pkg::*;
(
    input  logic [31:0] mem_word,
    input  logic [1:0]  byte_off,
    input  logic [2:0]  funct3,
    input  logic [31:0] store_data,
    output logic [31:0] load_data,
    output logic [31:0] merged_word
);

    logic [7:0]  byte_s;
    logic [15:0] half_s;
    logic [31:0] mask_s;
    logic [31:0] lane_data_s;

    // Load path: pick the addressed byte/halfword and extend it.
    always_comb begin
        byte_s    = 8'h00;
        half_s    = 16'h0000;
        load_data = 32'h0000_0000;
        case (byte_off)
            2'b00:   byte_s = mem_word[7:0];
            2'b01:   byte_s = mem_word[15:8];
            2'b10:   byte_s = mem_word[23:16];
            2'b11:   byte_s = mem_word[31:24];
            default: byte_s = 8'h00;
        endcase
        // Halfword lane is chosen by bit 1 only; bit 0 is either checked upstream or ignored.
        if (byte_off[1]) begin
            half_s = mem_word[31:16];
        end else begin
            half_s = mem_word[15:0];
        end
        case (funct3)
            F3_B:    load_data = {{24{byte_s[7]}}, byte_s};
            F3_BU:   load_data = {24'h00_0000, byte_s};
            F3_H:    load_data = {{16{half_s[15]}}, half_s};
            F3_HU:   load_data = {16'h0000, half_s};
            F3_W:    load_data = mem_word;
            default: load_data = 32'h0000_0000;
        endcase
    end

    // Store path: replicate store data across lanes, then mask it into the old word.
    always_comb begin
        mask_s = lane_mask(funct3, byte_off);
        case (funct3)
            F3_B:    lane_data_s = {4{store_data[7:0]}};
            F3_H:    lane_data_s = {2{store_data[15:0]}};
            default: lane_data_s = store_data;
        endcase
        merged_word = (mem_word & ~mask_s) | (lane_data_s & mask_s);
    end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit between the core and a word-addressed data memory.
// Loads complete in the same cycle; SW writes in one cycle; SB/SH run as a
// two-cycle read-modify-write with the core stalled during the read cycle.
// Ports:
//   clock, reset_n                      clock (rising edge), async active-low reset
//   MemRead, MemWrite, funct3           core request (both high = store)
//   address, write_data                 byte address and right-aligned store data
//   read_data, stall, misaligned        results back to the core
//   mem_MemRead, mem_MemWrite,
//   mem_address, mem_write_data         memory request (address always word aligned)
//   mem_read_data                       combinational memory read data
// Optional build macro: LSU_MISALIGN_CHECK_EN -- flags and suppresses misaligned
// H/HU/SH and W/SW accesses; when undefined, misaligned is 0 and low bits are ignored.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  MemRead,
    input  logic                  MemWrite,
    input  logic [2:0]            funct3,
    input  logic [ADDR_WIDTH-1:0] address,
    input  logic [DATA_WIDTH-1:0] write_data,
    output logic [DATA_WIDTH-1:0] read_data,
    output logic                  stall,
    output logic                  misaligned,
    output logic                  mem_MemRead,
    output logic                  mem_MemWrite,
    output logic [ADDR_WIDTH-1:0] mem_address,
    output logic [DATA_WIDTH-1:0] mem_write_data,
    input  logic [DATA_WIDTH-1:0] mem_read_data
);

    generate
        if (DATA_WIDTH != 32) begin : g_width_check
            $error("load_store_unit supports DATA_WIDTH == 32 only");
        end
    endgenerate

    lsu_state_e            state_r;
    lsu_state_e            state_next_s;
    logic [ADDR_WIDTH-1:0] addr_r;
    logic [2:0]            funct3_r;
    logic [DATA_WIDTH-1:0] data_r;

    logic                  capture_s;
    logic                  is_store_s;
    logic                  is_load_s;
    logic                  legal_load_s;
    logic                  legal_store_s;
    logic                  mis_s;
    logic                  rmw_valid_s;
    logic [ADDR_WIDTH-1:0] word_addr_s;
    logic [DATA_WIDTH-1:0] load_data_s;
    logic [DATA_WIDTH-1:0] merged_s;

    lsu_extract_merge u_extract_merge (
        .mem_word    (mem_read_data),
        .byte_off    (address[1:0]),
        .funct3      (funct3),
        .store_data  (write_data),
        .load_data   (load_data_s),
        .merged_word (merged_s)
    );

    // Request decode: store wins when both strobes are high; stores have no unsigned forms.
    always_comb begin
        is_store_s    = MemWrite;
        is_load_s     = MemRead & ~MemWrite;
        legal_load_s  = (funct3 == F3_B) || (funct3 == F3_H) || (funct3 == F3_W) ||
                        (funct3 == F3_BU) || (funct3 == F3_HU);
        legal_store_s = (funct3 == F3_B) || (funct3 == F3_H) || (funct3 == F3_W);
        word_addr_s   = {address[ADDR_WIDTH-1:2], 2'b00};
        // The captured width must be a sub-word store; anything else means corrupted state.
        rmw_valid_s   = (funct3_r == F3_B) || (funct3_r == F3_H);
`ifdef LSU_MISALIGN_CHECK_EN
        mis_s = (((funct3 == F3_H) || (funct3 == F3_HU)) && address[0]) ||
                ((funct3 == F3_W) && (address[1:0] != 2'b00));
`else
        mis_s = 1'b0;
`endif
    end

    // Next state and all outputs; everything is held at 0 while reset_n is low.
    always_comb begin
        read_data      = {DATA_WIDTH{1'b0}};
        stall          = 1'b0;
        misaligned     = 1'b0;
        mem_MemRead    = 1'b0;
        mem_MemWrite   = 1'b0;
        mem_address    = {ADDR_WIDTH{1'b0}};
        mem_write_data = {DATA_WIDTH{1'b0}};
        capture_s      = 1'b0;
        state_next_s   = state_r;
        if (!reset_n) begin
            state_next_s = ST_IDLE;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (is_store_s && legal_store_s) begin
                        if (mis_s) begin
                            misaligned = 1'b1;
                        end else if (funct3 == F3_W) begin
                            mem_MemWrite   = 1'b1;
                            mem_address    = word_addr_s;
                            mem_write_data = write_data;
                        end else begin
                            // Sub-word store: read the old word now, write the merge next cycle.
                            mem_MemRead  = 1'b1;
                            mem_address  = word_addr_s;
                            stall        = 1'b1;
                            capture_s    = 1'b1;
                            state_next_s = ST_RMW_WRITE;
                        end
                    end else if (is_load_s && legal_load_s) begin
                        if (mis_s) begin
                            misaligned = 1'b1;
                        end else begin
                            mem_MemRead = 1'b1;
                            mem_address = word_addr_s;
                            read_data   = load_data_s;
                        end
                    end else begin
                        // No request or illegal funct3: no access at all.
                        state_next_s = ST_IDLE;
                    end
                end
                ST_RMW_WRITE: begin
                    // Core inputs are ignored here; only captured state drives memory.
                    mem_MemWrite   = rmw_valid_s;
                    mem_address    = addr_r;
                    mem_write_data = data_r;
                    state_next_s   = ST_IDLE;
                end
                default: begin
                    state_next_s = ST_IDLE;
                end
            endcase
        end
    end

    // State register and RMW capture of address, width and merged word.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_r  <= ST_IDLE;
            addr_r   <= {ADDR_WIDTH{1'b0}};
            funct3_r <= 3'b000;
            data_r   <= {DATA_WIDTH{1'b0}};
        end else begin
            state_r <= state_next_s;
            if (capture_s) begin
                addr_r   <= word_addr_s;
                funct3_r <= funct3;
                data_r   <= merged_s;
            end
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit with a behavioural word memory.
module tb_load_store_unit;

    typedef struct packed {
        logic [31:0] rd;
        logic        stall;
        logic        mrd;
        logic        mwr;
        logic [31:0] maddr;
        logic [31:0] mwd;
        logic        mis;
    } exp_t;

    logic        clock;
    logic        reset_n;
    logic        MemRead;
    logic        MemWrite;
    logic [2:0]  funct3;
    logic [31:0] address;
    logic [31:0] write_data;
    logic [31:0] read_data;
    logic        stall;
    logic        misaligned;
    logic        mem_MemRead;
    logic        mem_MemWrite;
    logic [31:0] mem_address;
    logic [31:0] mem_write_data;
    logic [31:0] mem_read_data;

    logic [31:0] mem [0:1023];

    exp_t  exp_q[$];
    string name_q[$];
    int    n_checks;
    int    n_fail;

    load_store_unit #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
        .clock          (clock),
        .reset_n        (reset_n),
        .MemRead        (MemRead),
        .MemWrite       (MemWrite),
        .funct3         (funct3),
        .address        (address),
        .write_data     (write_data),
        .read_data      (read_data),
        .stall          (stall),
        .misaligned     (misaligned),
        .mem_MemRead    (mem_MemRead),
        .mem_MemWrite   (mem_MemWrite),
        .mem_address    (mem_address),
        .mem_write_data (mem_write_data),
        .mem_read_data  (mem_read_data)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Word memory: combinational read, synchronous write.
    assign mem_read_data = mem[mem_address[11:2]];
    always @(posedge clock) begin
        if (mem_MemWrite) mem[mem_address[11:2]] <= mem_write_data;
    end

    function automatic exp_t e_idle();
        exp_t e;
        e = '{rd: 32'h0, stall: 1'b0, mrd: 1'b0, mwr: 1'b0, maddr: 32'h0, mwd: 32'h0, mis: 1'b0};
        return e;
    endfunction

    function automatic exp_t e_load(input logic [31:0] a, input logic [31:0] d);
        exp_t e;
        e = e_idle();
        e.rd = d; e.mrd = 1'b1; e.maddr = a;
        return e;
    endfunction

    function automatic exp_t e_write(input logic [31:0] a, input logic [31:0] d);
        exp_t e;
        e = e_idle();
        e.mwr = 1'b1; e.maddr = a; e.mwd = d;
        return e;
    endfunction

    function automatic exp_t e_rmw_read(input logic [31:0] a);
        exp_t e;
        e = e_idle();
        e.stall = 1'b1; e.mrd = 1'b1; e.maddr = a;
        return e;
    endfunction

    function automatic exp_t e_mis();
        exp_t e;
        e = e_idle();
        e.mis = 1'b1;
        return e;
    endfunction

    task automatic chk(input string nm, input string fld, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s.%s actual=%08h required=%08h", nm, fld, act, exp);
        end
    endtask

    // Monitor: every cycle with a pending expectation is compared mid-cycle.
    always @(negedge clock) begin
        exp_t  e;
        string nm;
        if (exp_q.size() > 0) begin
            e  = exp_q.pop_front();
            nm = name_q.pop_front();
            chk(nm, "read_data",      read_data,              e.rd);
            chk(nm, "stall",          {31'h0, stall},         {31'h0, e.stall});
            chk(nm, "mem_MemRead",    {31'h0, mem_MemRead},   {31'h0, e.mrd});
            chk(nm, "mem_MemWrite",   {31'h0, mem_MemWrite},  {31'h0, e.mwr});
            chk(nm, "mem_address",    mem_address,            e.maddr);
            chk(nm, "mem_write_data", mem_write_data,         e.mwd);
            chk(nm, "misaligned",     {31'h0, misaligned},    {31'h0, e.mis});
        end
    end

    // One core cycle: drive just after the rising edge and queue what the DUT must show.
    task automatic step(input logic mr, input logic mw, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] wd,
                        input string nm, input exp_t e);
        @(posedge clock);
        #1;
        MemRead = mr; MemWrite = mw; funct3 = f3; address = a; write_data = wd;
        exp_q.push_back(e);
        name_q.push_back(nm);
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        // Reset held with a live load request: all outputs must still be 0.
        reset_n = 1'b0;
        MemRead = 1'b1; MemWrite = 1'b0; funct3 = 3'b010; address = 32'h100; write_data = 32'h0;
        #2;
        exp_q.push_back(e_idle());
        name_q.push_back("reset_outputs");
        #10;
        reset_n = 1'b1;
        MemRead = 1'b0;

        step(1'b0, 1'b0, 3'b010, 32'h100, 32'h0, "no_request", e_idle());

        // Loads from 0x80F0_7F01 at 0x100.
        step(1'b0, 1'b1, 3'b010, 32'h100, 32'h80F0_7F01, "sw_preload", e_write(32'h100, 32'h80F0_7F01));
        step(1'b1, 1'b0, 3'b000, 32'h103, 32'h0, "lb_103",  e_load(32'h100, 32'hFFFF_FF80));
        step(1'b1, 1'b0, 3'b100, 32'h103, 32'h0, "lbu_103", e_load(32'h100, 32'h0000_0080));
        step(1'b1, 1'b0, 3'b001, 32'h102, 32'h0, "lh_102",  e_load(32'h100, 32'hFFFF_80F0));
        step(1'b1, 1'b0, 3'b101, 32'h100, 32'h0, "lhu_100", e_load(32'h100, 32'h0000_7F01));
        step(1'b1, 1'b0, 3'b000, 32'h101, 32'h0, "lb_101",  e_load(32'h100, 32'h0000_007F));
        step(1'b1, 1'b0, 3'b010, 32'h100, 32'h0, "lw_100",  e_load(32'h100, 32'h80F0_7F01));
        step(1'b1, 1'b0, 3'b011, 32'h100, 32'h0, "illegal_load", e_idle());

        // SB 0xAB to 0x101 over 0x1122_3344; request held through the write cycle.
        step(1'b0, 1'b1, 3'b010, 32'h100, 32'h1122_3344, "sw_sb_base", e_write(32'h100, 32'h1122_3344));
        step(1'b0, 1'b1, 3'b000, 32'h101, 32'hFFFF_FFAB, "sb_read",  e_rmw_read(32'h100));
        step(1'b0, 1'b1, 3'b000, 32'h101, 32'hFFFF_FFAB, "sb_write", e_write(32'h100, 32'h1122_AB44));
        step(1'b0, 1'b1, 3'b111, 32'h100, 32'h0, "illegal_store", e_idle());
        step(1'b1, 1'b0, 3'b010, 32'h100, 32'h0, "sb_readback", e_load(32'h100, 32'h1122_AB44));

        // SW with both strobes high behaves as a store.
        step(1'b1, 1'b1, 3'b010, 32'h200, 32'hDEAD_BEEF, "sw_200", e_write(32'h200, 32'hDEAD_BEEF));
        step(1'b1, 1'b0, 3'b010, 32'h200, 32'h0, "sw_readback", e_load(32'h200, 32'hDEAD_BEEF));

        // Back-to-back SH into a zeroed word.
        step(1'b0, 1'b1, 3'b010, 32'h300, 32'h0, "sw_zero_300", e_write(32'h300, 32'h0));
        step(1'b0, 1'b1, 3'b001, 32'h300, 32'h0000_1234, "sh1_read",  e_rmw_read(32'h300));
        step(1'b0, 1'b1, 3'b001, 32'h300, 32'h0000_1234, "sh1_write", e_write(32'h300, 32'h0000_1234));
        step(1'b0, 1'b1, 3'b001, 32'h302, 32'h0000_5678, "sh2_read",  e_rmw_read(32'h300));
        step(1'b0, 1'b1, 3'b001, 32'h302, 32'h0000_5678, "sh2_write", e_write(32'h300, 32'h5678_1234));
        step(1'b1, 1'b0, 3'b010, 32'h300, 32'h0, "sh_readback", e_load(32'h300, 32'h5678_1234));

        // Misaligned accesses.
`ifdef LSU_MISALIGN_CHECK_EN
        step(1'b1, 1'b0, 3'b010, 32'h102, 32'h0, "lw_102_mis", e_mis());
        step(1'b0, 1'b1, 3'b001, 32'h101, 32'h0000_9999, "sh_101_mis", e_mis());
        step(1'b1, 1'b0, 3'b010, 32'h100, 32'h0, "mis_readback", e_load(32'h100, 32'h1122_AB44));
`else
        step(1'b1, 1'b0, 3'b010, 32'h102, 32'h0, "lw_102", e_load(32'h100, 32'h1122_AB44));
        step(1'b0, 1'b1, 3'b001, 32'h101, 32'h0000_9999, "sh_101_read",  e_rmw_read(32'h100));
        step(1'b0, 1'b1, 3'b001, 32'h101, 32'h0000_9999, "sh_101_write", e_write(32'h100, 32'h1122_9999));
        step(1'b1, 1'b0, 3'b010, 32'h100, 32'h0, "sh_101_readback", e_load(32'h100, 32'h1122_9999));
`endif

        // Reset during the RMW write cycle must abandon the write.
        step(1'b0, 1'b1, 3'b010, 32'h104, 32'hCAFE_F00D, "sw_104", e_write(32'h104, 32'hCAFE_F00D));
        step(1'b0, 1'b1, 3'b000, 32'h104, 32'h0000_0055, "sb_104_read",  e_rmw_read(32'h104));
        step(1'b0, 1'b1, 3'b000, 32'h104, 32'h0000_0055, "sb_104_write", e_write(32'h104, 32'hCAFE_F055));
        @(negedge clock);
        #2;
        reset_n = 1'b0;
        exp_q.push_back(e_idle());
        name_q.push_back("reset_in_rmw");
        @(negedge clock);
        #2;
        reset_n = 1'b1;
        MemRead = 1'b0; MemWrite = 1'b0;
        step(1'b0, 1'b0, 3'b000, 32'h0, 32'h0, "post_reset_idle", e_idle());
        step(1'b1, 1'b0, 3'b010, 32'h104, 32'h0, "rmw_abort_readback", e_load(32'h104, 32'hCAFE_F00D));
        step(1'b0, 1'b0, 3'b000, 32'h0, 32'h0, "final_idle", e_idle());

        repeat (3) @(posedge clock);
        chk("scoreboard_drain", "pending", exp_q.size(), 32'h0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
